// File: rtl/accum_bank.sv
// Accumulator bank: NACC registers of WIDTH bits with load, ALU update and a
// bit-serial shift-add multiply behind a valid/ready command port. Status flags
// hold carry/borrow, zero and MSB of the last completed operation.
module accum_bank #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NACC  = 4,
  parameter bit          SAT   = 1'b0,
  localparam int unsigned SW   = $clog2(NACC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [SW-1:0]    sel,
  input  logic [WIDTH-1:0] data,
  input  logic [SW-1:0]    rd_sel,
  output logic [WIDTH-1:0] acc_out,
  output logic             done,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  localparam logic [2:0] OpNop  = 3'd0;
  localparam logic [2:0] OpLoad = 3'd1;
  localparam logic [2:0] OpAdd  = 3'd2;
  localparam logic [2:0] OpSub  = 3'd3;
  localparam logic [2:0] OpAnd  = 3'd4;
  localparam logic [2:0] OpXor  = 3'd5;
  localparam logic [2:0] OpShl  = 3'd6;
  localparam logic [2:0] OpMul  = 3'd7;

  typedef enum logic {StIdle, StMul} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0]   acc_q [NACC];
  logic [WIDTH-1:0]   acc_d [NACC];
  logic               flag_c_q, flag_c_d;
  logic               flag_z_q, flag_z_d;
  logic               flag_n_q, flag_n_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]      msel_q, msel_d;

  logic               accept;
  logic               last_step;
  logic [WIDTH-1:0]   cur;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH:0]     step;
  logic [WIDTH-1:0]   res;
  logic               carry;
  logic               commit;
  logic [SW-1:0]      wr_sel;

  assign accept    = in_valid && (state_q == StIdle);
  assign last_step = (cnt_q == CntW'(1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: enter StMul on a MUL accept, leave when the counter expires
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept && (op == OpMul)) state_d = StMul;
      StMul:  if (last_step) state_d = StIdle;
    endcase
  end

  // Datapath registers; reset discards any in-flight multiply
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NACC); i++) acc_q[i] <= '0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
      done_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      msel_q   <= '0;
    end else begin
      acc_q    <= acc_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
      flag_n_q <= flag_n_d;
      done_q   <= done_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      msel_q   <= msel_d;
    end
  end

  // Datapath next state: single-cycle ops commit at accept, MUL steps one bit per cycle
  always_comb begin
    acc_d    = acc_q;
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    flag_n_d = flag_n_q;
    done_d   = 1'b0;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    msel_d   = msel_q;
    cur      = acc_q[sel];
    sum      = {1'b0, cur} + {1'b0, data};
    diff     = {1'b0, cur} - {1'b0, data};
    step     = '0;
    res      = '0;
    carry    = 1'b0;
    commit   = 1'b0;
    wr_sel   = sel;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          done_d = (op != OpMul);
          commit = (op != OpMul) && (op != OpNop);
          unique case (op)
            OpNop:  res = cur;
            OpLoad: res = data;
            OpAdd: begin
              carry = sum[WIDTH];
              res   = (SAT && carry) ? '1 : sum[WIDTH-1:0];
            end
            OpSub: begin
              carry = diff[WIDTH];
              res   = (SAT && carry) ? '0 : diff[WIDTH-1:0];
            end
            OpAnd:  res = cur & data;
            OpXor:  res = cur ^ data;
            OpShl: begin
              carry = cur[WIDTH-1];
              res   = {cur[WIDTH-2:0], 1'b0};
            end
            OpMul: begin
              mcand_d  = cur;
              mplier_d = data;
              prod_d   = '0;
              cnt_d    = CntW'(WIDTH);
              msel_d   = sel;
            end
          endcase
        end
      end
      StMul: begin
        // Right-shifting partial product: add multiplicand into the top half,
        // then shift the whole product down one place.
        step     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        prod_d   = {step, prod_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CntW'(1);
        if (last_step) begin
          res    = prod_d[WIDTH-1:0];
          carry  = |prod_d[2*WIDTH-1:WIDTH];
          commit = 1'b1;
          done_d = 1'b1;
          wr_sel = msel_q;
        end
      end
    endcase
    if (commit) begin
      acc_d[wr_sel] = res;
      flag_c_d      = carry;
      flag_z_d      = (res == '0);
      flag_n_d      = res[WIDTH-1];
    end
  end

  // Outputs: ready when idle, committed register read, registered status
  always_comb begin
    in_ready = (state_q == StIdle);
    acc_out  = acc_q[rd_sel];
    done     = done_q;
    flag_c   = flag_c_q;
    flag_z   = flag_z_q;
    flag_n   = flag_n_q;
  end

endmodule

// File: doc/accum_bank.md
# accum_bank

Parametrised accumulator bank for the simplified RISC CPU datapath. It replaces the single 8-bit load-only accumulator with NACC accumulators of WIDTH bits. Each accumulator supports load, ALU-style update, and a multi-cycle shift-add multiply under a valid/ready command handshake. Global status flags from the last completed operation feed the controller's branch logic.

## Interface
- WIDTH, 8, accumulator and data width (≥ 2)
- NACC, 4, number of accumulators (power of 2, ≥ 2); SW = log2(NACC)
- SAT, 0, 1 = unsigned saturating ADD/SUB; 0 = wrap-around
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  command present
- in_ready  out  1  block can accept a command (= not busy)
- op  in  3  opcode: 0 NOP, 1 LOAD, 2 ADD, 3 SUB, 4 AND, 5 XOR, 6 SHL, 7 MUL
- sel  in  SW  target accumulator index
- data  in  WIDTH  operand
- rd_sel  in  SW  read-port index
- acc_out  out  WIDTH  combinational read of accumulator rd_sel
- done  out  1  one-cycle pulse: command completed
- flag_c, flag_z, flag_n  out  1 each  carry/borrow, zero, MSB of last result

## Operation
- Accept: in_valid && in_ready at a rising edge; op/sel/data sampled only then.
- Single-cycle ops write acc[sel] at the accept edge:
  - LOAD: data.
  - ADD: acc+data; C = carry out.
  - SUB: acc−data; C = borrow (acc < data).
  - AND/XOR: bitwise; C = 0.
  - SHL: acc<<1; C = old MSB; data ignored.
- SAT=1: ADD with carry → all-ones; SUB with borrow → 0; C still reports carry/borrow.
- Z = (result == 0); N = result[WIDTH−1]. Flags update only on completion; NOP leaves acc and flags unchanged but still pulses done.
- MUL: acc[sel] ← low WIDTH bits of acc[sel]×data (unsigned); C = 1 iff upper WIDTH bits of full product ≠ 0.
- MUL is implemented as a two-state FSM, IDLE → MUL on MUL accept.
  - Latches multiplicand, multiplier, sel and a 2·WIDTH-bit partial product.
  - Processes one multiplier bit per cycle under a down-counter of WIDTH.
  - Returns to IDLE on the cycle the counter expires; the result is written then.
- acc_out reflects committed register contents only; it shows the old value during MUL.
- Other accumulators are never modified by an operation on sel.

## Timing
- Reset (rst=1 at an edge), regardless of state:
  - all accumulators 0; flags 0; done 0; FSM IDLE; counter 0; in_ready 1 in the following cycle.
  - An in-flight MUL is discarded with no write.
- Single-cycle op accepted at edge k:
  - acc and flags updated at k; done = 1 for the cycle after k.
  - in_ready stays 1, so back-to-back commands are accepted every cycle.
- MUL accepted at edge k:
  - in_ready = 0 from after k through edge k+WIDTH.
  - acc, flags written at edge k+WIDTH; done high and in_ready = 1 in the cycle after k+WIDTH.
- in_valid while in_ready = 0: the command is held, not dropped; it is accepted at the first edge with in_ready = 1.
- The requester must keep op/sel/data stable while in_valid is high and not yet accepted.
- The read port is purely combinational: acc_out follows rd_sel within the same cycle, with no added latency.

## Test plan
- Reset: rst for 2 cycles, then release → acc_out 0 for every rd_sel 0..3, flags 000, done 0, in_ready 1.
- LOAD acc2 ← 0xF0, ADD acc2 0x20, back-to-back:
  - SAT=0 → acc2 = 0x10, C=1, Z=0, N=0, done on two consecutive cycles.
  - SAT=1 → acc2 = 0xFF, C=1, N=1.
- LOAD acc1 ← 0x10, SUB 0x10 → 0x00, Z=1, C=0.
- Then SUB 0x01:
  - SAT=0 → 0xFF, C=1, N=1.
  - SAT=1 → 0x00, C=1, Z=1.
  - acc0, acc2 and acc3 unchanged.
- MUL acc3 = 0x0D × 0x0B:
  - in_ready low 8 cycles, acc3 = 0x8F, C=0, done 9 cycles after accept.
  - A second MUL 0x20 × 0x10 → 0x00, Z=1, C=1.
- During MUL, hold in_valid with LOAD acc0 ← 0x55:
  - not accepted while busy.
  - accepted on the edge after done's cycle begins.
  - acc0 = 0x55 one cycle later; acc_out with rd_sel=3 shows the pre-MUL value until the write edge.
- rst pulsed 4 cycles into a MUL:
  - no result write, no done pulse.
  - all accumulators 0, in_ready 1 next cycle.
  - a following LOAD accepted normally.
